// File: rtl/aes_round_pipe.sv
`default_nettype none
// ============================================================================
// aes_round_pipe : elastic valid/ready register pipe for AES round state, key,
//                  Rcon and last-round flag. Optional macro: AES_PIPE_PARITY_EN
// Rev 1.0
// ============================================================================
module aes_round_pipe #(
  parameter int DATA_W = 128,
  parameter int KEY_W  = 128,
  parameter int RCON_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_state,
  input  logic [KEY_W-1:0]             in_key,
  input  logic [RCON_W-1:0]            in_rcon,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_state,
  output logic [KEY_W-1:0]             out_key,
  output logic [RCON_W-1:0]            out_rcon,
  output logic                         out_last,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         parity_err
);
  localparam int PW    = DATA_W + KEY_W + RCON_W + 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]          vld_q;
  logic [DEPTH-1:0]          vld_d;
  logic [DEPTH-1:0]          en;
  logic [DEPTH-1:0]          up_vld;
  logic [DEPTH-1:0][PW-1:0]  pay_q;
  logic [PW-1:0]             in_pay;
  logic                      take;
  logic                      carry;
  logic [OCC_W-1:0]          occ_q;
  logic [OCC_W-1:0]          occ_d;

  assign in_pay = {in_state, in_key, in_rcon, in_last};

  // en[i]: register i may load this cycle (it is empty, or everything ahead of it
  // moves). Walking from the output back collapses bubbles in a single cycle.
  always_comb begin
    carry = out_ready;
    en    = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      carry = carry | ~vld_q[i];
      en[i] = carry;
    end
  end

  assign in_ready = en[0];
  assign take     = in_valid & en[0];

  always_comb begin
    up_vld    = '0;
    up_vld[0] = take;
    for (int i = 1; i < DEPTH; i++) begin
      up_vld[i] = vld_q[i-1];
    end
    vld_d = (en & up_vld) | (~en & vld_q);
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + OCC_W'(vld_d[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
      pay_q <= '0;
      occ_q <= '0;
    end else if (flush) begin
      vld_q <= '0;
      occ_q <= '0;
    end else begin
      vld_q <= vld_d;
      occ_q <= occ_d;
      if (take) begin
        pay_q[0] <= in_pay;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (en[i] && vld_q[i-1]) begin
          pay_q[i] <= pay_q[i-1];
        end
      end
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign {out_state, out_key, out_rcon, out_last} = pay_q[DEPTH-1];
  assign occupancy = occ_q;

`ifdef AES_PIPE_PARITY_EN
  logic [DEPTH-1:0] par_q;
  logic             err_q;

  // Even parity: payload bits plus the carried parity bit XOR to zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      par_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (vld_q[DEPTH-1] && ((^pay_q[DEPTH-1]) != par_q[DEPTH-1])) begin
        err_q <= 1'b1;
      end
      if (!flush) begin
        if (take) begin
          par_q[0] <= ^in_pay;
        end
        for (int i = 1; i < DEPTH; i++) begin
          if (en[i] && vld_q[i-1]) begin
            par_q[i] <= par_q[i-1];
          end
        end
      end
    end
  end

  assign parity_err = err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire
